bp_load_scheduler: RTL and testbench

Sequences the BP FIFO controller across a multi-tile load job. It issues one configuration pulse per tile with the tile's DDR address, byte count, BP start address and bank, then waits for the controller to finish. It ping-pongs between two BP banks and holds each bank until the downstream compute releases it. It sits between the layer-level control FSM and the BP FIFO controller.

---
 rtl/bp_sched_pkg.sv | 25 ++
 rtl/bp_bank_tracker.sv | 34 +++
 rtl/bp_load_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_bp_load_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_sched_pkg.sv
// Shared definitions for the BP load scheduler.
//   state_e       : scheduler FSM encoding
//   NUM_BANKS     : number of ping-pong BP banks
//   BANK*_ST_NUM  : first BP line used by each bank
//   bank_st_num() : maps a bank index to its first BP line
package bp_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBank,
    StConf,
    StWaitAck,
    StWaitIdle,
    StDone
  } state_e;

  localparam int unsigned NUM_BANKS    = 2;
  localparam logic [1:0]  BANK0_ST_NUM = 2'd0;
  localparam logic [1:0]  BANK1_ST_NUM = 2'd2;

  function automatic logic [1:0] bank_st_num(input logic bank);
    return bank ? BANK1_ST_NUM : BANK0_ST_NUM;
  endfunction

endpackage

// File: rtl/bp_bank_tracker.sv
// Per-bank "holds a complete tile" flags.
//   clk, rst  : clock, asynchronous active-high reset
//   i_set     : one-cycle set pulse per bank (producer finished a tile)
//   i_release : one-cycle release pulse per bank (consumer done)
//   o_valid   : registered bank-valid flags
// A set and a release of the same bank in one cycle leaves the bank valid.
module bp_bank_tracker
  import bp_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] i_set,
  input  logic [NUM_BANKS-1:0] i_release,
  output logic [NUM_BANKS-1:0] o_valid
);

  logic [NUM_BANKS-1:0] r_valid;
  logic [NUM_BANKS-1:0] w_valid_d;

  always_comb begin
    w_valid_d = (r_valid & ~i_release) | i_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_d;
    end
  end

  assign o_valid = r_valid;

endmodule

// File: rtl/bp_load_scheduler.sv
// Multi-tile BP load sequencer: issues one configure pulse per tile to the BP FIFO
// controller, waits for it to go busy then idle, and ping-pongs between two BP banks.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : job start (ignored unless idle); job inputs latched on accept
//   ddr_base, tile_stride, tile_ddr_byte, tile_num, bp_base, line_width : job inputs
//   bp_conf, bp_ddr_st_addr, bp_data_ddr_byte, bp_st_addr, bp_st_num, bp_line_width,
//   bp_idle          : FIFO controller handshake
//   bank_valid, bank_release : bank ownership with the downstream consumer
//   busy, done, err  : job status
// Optional watchdog enabled by defining BP_SCHED_TIMEOUT_EN.
module bp_load_scheduler #(
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned ADDR_LEN     = 16,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned TILE_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC  = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DDR_ADDR_LEN-1:0] ddr_base,
  input  logic [DDR_ADDR_LEN-1:0] tile_stride,
  input  logic [SINGLE_LEN-1:0]   tile_ddr_byte,
  input  logic [TILE_LEN-1:0]     tile_num,
  input  logic [ADDR_LEN-1:0]     bp_base,
  input  logic [SINGLE_LEN-1:0]   line_width,
  output logic                    bp_conf,
  output logic [DDR_ADDR_LEN-1:0] bp_ddr_st_addr,
  output logic [SINGLE_LEN-1:0]   bp_data_ddr_byte,
  output logic [ADDR_LEN-1:0]     bp_st_addr,
  output logic [1:0]              bp_st_num,
  output logic [SINGLE_LEN-1:0]   bp_line_width,
  input  logic                    bp_idle,
  output logic [1:0]              bank_valid,
  input  logic [1:0]              bank_release,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  import bp_sched_pkg::*;

  state_e r_state, w_state_d;

  // Latched job parameters
  logic [DDR_ADDR_LEN-1:0] r_stride;
  logic [SINGLE_LEN-1:0]   r_byte;
  logic [TILE_LEN-1:0]     r_tile_num;
  logic [ADDR_LEN-1:0]     r_bp_base;
  logic [SINGLE_LEN-1:0]   r_line_width;

  // Per-tile progress
  logic [TILE_LEN-1:0]     r_tile_idx;
  logic [DDR_ADDR_LEN-1:0] r_cur_addr;
  logic                    r_bank;
  logic [1:0]              r_set;

  // Registered outputs
  logic                    r_bp_conf;
  logic [DDR_ADDR_LEN-1:0] r_bp_ddr_st_addr;
  logic [SINGLE_LEN-1:0]   r_bp_data_ddr_byte;
  logic [ADDR_LEN-1:0]     r_bp_st_addr;
  logic [1:0]              r_bp_st_num;
  logic [SINGLE_LEN-1:0]   r_bp_line_width;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_load;
  logic                    w_tile_done;
  logic                    w_abort;
  logic                    w_timeout;
  logic [1:0]              w_bank_valid;
  logic [TILE_LEN-1:0]     w_tile_idx_nxt;

  assign w_tile_idx_nxt = r_tile_idx + 1'b1;

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_tile_done = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept  = 1'b1;
          w_state_d = (tile_num == '0) ? StDone : StWaitBank;
        end
      end
      StWaitBank: begin
        if (!w_bank_valid[r_bank]) begin
          w_load    = 1'b1;
          w_state_d = StConf;
        end
      end
      StConf: w_state_d = StWaitAck;
      StWaitAck: begin
        if (w_timeout) begin
          w_abort   = 1'b1;
          w_state_d = StDone;
        end else if (!bp_idle) begin
          w_state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (w_timeout) begin
          w_abort   = 1'b1;
          w_state_d = StDone;
        end else if (bp_idle) begin
          w_tile_done = 1'b1;
          w_state_d   = (w_tile_idx_nxt == r_tile_num) ? StDone : StWaitBank;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= StIdle;
      r_stride           <= '0;
      r_byte             <= '0;
      r_tile_num         <= '0;
      r_bp_base          <= '0;
      r_line_width       <= '0;
      r_tile_idx         <= '0;
      r_cur_addr         <= '0;
      r_bank             <= 1'b0;
      r_set              <= '0;
      r_bp_conf          <= 1'b0;
      r_bp_ddr_st_addr   <= '0;
      r_bp_data_ddr_byte <= '0;
      r_bp_st_addr       <= '0;
      r_bp_st_num        <= '0;
      r_bp_line_width    <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      // Output pulses lag the state by one cycle so every output comes from a flop.
      r_bp_conf <= (r_state == StConf);
      r_done    <= (r_state == StDone);
      r_busy    <= (w_state_d != StIdle);
      r_set     <= '0;
      if (w_accept) begin
        r_stride     <= tile_stride;
        r_byte       <= tile_ddr_byte;
        r_tile_num   <= tile_num;
        r_bp_base    <= bp_base;
        r_line_width <= line_width;
        r_tile_idx   <= '0;
        r_cur_addr   <= ddr_base;
        r_bank       <= 1'b0;
      end
      // Loaded one cycle ahead of bp_conf; held until the next tile's load.
      if (w_load) begin
        r_bp_ddr_st_addr   <= r_cur_addr;
        r_bp_data_ddr_byte <= r_byte;
        r_bp_st_addr       <= r_bp_base;
        r_bp_st_num        <= bank_st_num(r_bank);
        r_bp_line_width    <= r_line_width;
      end
      if (w_tile_done) begin
        r_set[r_bank] <= 1'b1;
        r_tile_idx    <= w_tile_idx_nxt;
        r_cur_addr    <= r_cur_addr + r_stride;
        r_bank        <= ~r_bank;
      end
    end
  end

`ifdef BP_SCHED_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_err;

  assign w_timeout = (r_wdog == TIMEOUT_CYC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_state_d != r_state) begin
        r_wdog <= '0;
      end else if (r_state == StWaitAck || r_state == StWaitIdle) begin
        r_wdog <= r_wdog + 32'd1;
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unused_timeout;
  logic        w_unused_abort;

  assign w_unused_timeout = TIMEOUT_CYC;
  assign w_unused_abort   = w_abort;
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  bp_bank_tracker u_bank_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_set     (r_set),
    .i_release (bank_release),
    .o_valid   (w_bank_valid)
  );

  assign bp_conf          = r_bp_conf;
  assign bp_ddr_st_addr   = r_bp_ddr_st_addr;
  assign bp_data_ddr_byte = r_bp_data_ddr_byte;
  assign bp_st_addr       = r_bp_st_addr;
  assign bp_st_num        = r_bp_st_num;
  assign bp_line_width    = r_bp_line_width;
  assign bank_valid       = w_bank_valid;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_bp_load_scheduler.sv
// Directed bench for bp_load_scheduler. Define BP_SCHED_TIMEOUT_EN to also run the
// watchdog scenario (TIMEOUT_CYC is set to 16 here).
module tb_bp_load_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ddr_base;
  logic [31:0] tile_stride;
  logic [23:0] tile_ddr_byte;
  logic [15:0] tile_num;
  logic [15:0] bp_base;
  logic [23:0] line_width;
  logic        bp_conf;
  logic [31:0] bp_ddr_st_addr;
  logic [23:0] bp_data_ddr_byte;
  logic [15:0] bp_st_addr;
  logic [1:0]  bp_st_num;
  logic [23:0] bp_line_width;
  logic        bp_idle;
  logic [1:0]  bank_valid;
  logic [1:0]  bank_release;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_load_scheduler #(
    .DDR_ADDR_LEN (32),
    .ADDR_LEN     (16),
    .SINGLE_LEN   (24),
    .TILE_LEN     (16),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .ddr_base         (ddr_base),
    .tile_stride      (tile_stride),
    .tile_ddr_byte    (tile_ddr_byte),
    .tile_num         (tile_num),
    .bp_base          (bp_base),
    .line_width       (line_width),
    .bp_conf          (bp_conf),
    .bp_ddr_st_addr   (bp_ddr_st_addr),
    .bp_data_ddr_byte (bp_data_ddr_byte),
    .bp_st_addr       (bp_st_addr),
    .bp_st_num        (bp_st_num),
    .bp_line_width    (bp_line_width),
    .bp_idle          (bp_idle),
    .bank_valid       (bank_valid),
    .bank_release     (bank_release),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_conf"}, bp_conf, 0);
    chk({tag, "_addr"}, bp_ddr_st_addr, 0);
    chk({tag, "_byte"}, bp_data_ddr_byte, 0);
    chk({tag, "_bpaddr"}, bp_st_addr, 0);
    chk({tag, "_stnum"}, bp_st_num, 0);
    chk({tag, "_lw"}, bp_line_width, 0);
    chk({tag, "_valid"}, bank_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Waits (bounded) for bp_conf, checks the tile descriptor, then mimics the FIFO
  // controller: one cycle busy, then idle. Returns #1 after the edge that sees idle.
  task automatic serve(input string tag, input logic [31:0] exp_addr,
                       input logic [1:0] exp_num);
    int k = 0;
    while (bp_conf !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_conf_seen"}, bp_conf, 1);
    chk({tag, "_addr"}, bp_ddr_st_addr, exp_addr);
    chk({tag, "_stnum"}, bp_st_num, exp_num);
    bp_idle = 1'b0;
    step();
    chk({tag, "_conf_pulse"}, bp_conf, 0);
    bp_idle = 1'b1;
    step();
  endtask

  task automatic pulse_release(input logic [1:0] b);
    bank_release = b;
    step();
    bank_release = 2'b00;
  endtask

  task automatic job(input logic [31:0] base, input logic [31:0] stride,
                     input logic [15:0] n);
    ddr_base      = base;
    tile_stride   = stride;
    tile_num      = n;
    tile_ddr_byte = 24'h000800;
    bp_base       = 16'h0040;
    line_width    = 24'h000010;
    start         = 1'b1;
    step();
    start         = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    ddr_base      = '0;
    tile_stride   = '0;
    tile_ddr_byte = '0;
    tile_num      = '0;
    bp_base       = '0;
    line_width    = '0;
    bp_idle       = 1'b1;
    bank_release  = 2'b00;
    #3;
    chk_reset_outputs("rst");
    step();
    step();
    rst = 1'b0;
    step();

    // Basic job, with a start pulse while busy carrying different inputs
    job(32'h0000_1000, 32'h0000_0400, 16'd3);
    chk("basic_busy", busy, 1);
    chk("basic_conf_e0", bp_conf, 0);
    step();
    chk("basic_conf_e1", bp_conf, 0);
    chk("basic_preaddr", bp_ddr_st_addr, 32'h0000_1000);
    chk("basic_byte", bp_data_ddr_byte, 24'h000800);
    chk("basic_bpaddr", bp_st_addr, 16'h0040);
    chk("basic_lw", bp_line_width, 24'h000010);
    ddr_base      = 32'hDEAD_0000;
    tile_stride   = 32'h0000_0004;
    tile_num      = 16'd0;
    tile_ddr_byte = 24'h123456;
    start         = 1'b1;
    step();
    start         = 1'b0;
    chk("basic_conf_e2", bp_conf, 1);
    serve("basic_t0", 32'h0000_1000, 2'd0);
    chk("basic_set_lag", bank_valid, 2'b00);
    step();
    chk("basic_set0", bank_valid, 2'b01);
    pulse_release(2'b01);
    chk("basic_rel0", bank_valid, 2'b00);
    serve("basic_t1", 32'h0000_1400, 2'd2);
    chk("basic_byte_held", bp_data_ddr_byte, 24'h000800);
    step();
    chk("basic_set1", bank_valid, 2'b10);
    pulse_release(2'b10);
    serve("basic_t2", 32'h0000_1800, 2'd0);
    chk("basic_done_early", done, 0);
    step();
    chk("basic_done", done, 1);
    chk("basic_set2", bank_valid, 2'b01);
    chk("basic_err", err, 0);
    step();
    chk("basic_done_pulse", done, 0);
    chk("basic_idle", busy, 0);

    // Release of a free bank is ignored; valid bank persists across the job end
    pulse_release(2'b10);
    chk("rel_free", bank_valid, 2'b01);
    pulse_release(2'b01);
    chk("rel_bank0", bank_valid, 2'b00);

    // Back-pressure: bank 0 kept valid, third tile stalls until released
    job(32'h0000_2000, 32'h0000_0100, 16'd3);
    serve("bp_t0", 32'h0000_2000, 2'd0);
    bank_release = 2'b01;  // lands on the same edge as the bank-0 set
    step();
    bank_release = 2'b00;
    chk("set_wins", bank_valid, 2'b01);
    serve("bp_t1", 32'h0000_2100, 2'd2);
    step();
    chk("bp_both", bank_valid, 2'b11);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_stall_conf", bp_conf, 0);
    end
    chk("bp_stall_busy", busy, 1);
    pulse_release(2'b01);
    chk("bp_rel_c0", bp_conf, 0);
    step();
    chk("bp_rel_c1", bp_conf, 0);
    step();
    chk("bp_rel_c2", bp_conf, 1);
    serve("bp_t2", 32'h0000_2200, 2'd0);
    step();
    chk("bp_done", done, 1);
    chk("bp_valid_end", bank_valid, 2'b11);
    pulse_release(2'b11);
    chk("bp_clear", bank_valid, 2'b00);

    // Zero tiles
    job(32'h0000_9000, 32'h0000_0100, 16'd0);
    chk("zero_busy", busy, 1);
    chk("zero_done_e0", done, 0);
    step();
    chk("zero_done_e1", done, 1);
    chk("zero_conf", bp_conf, 0);
    step();
    chk("zero_done_e2", done, 0);
    chk("zero_idle", busy, 0);
    chk("zero_valid", bank_valid, 2'b00);

    // Address wrap
    job(32'hFFFF_FC00, 32'h0000_0400, 16'd2);
    serve("wrap_t0", 32'hFFFF_FC00, 2'd0);
    serve("wrap_t1", 32'h0000_0000, 2'd2);
    step();
    chk("wrap_done", done, 1);
    chk("wrap_valid", bank_valid, 2'b11);
    pulse_release(2'b11);

`ifdef BP_SCHED_TIMEOUT_EN
    // Watchdog: FIFO never returns to idle
    begin
      int k = 0;
      job(32'h0000_5000, 32'h0000_0100, 16'd2);
      while (bp_conf !== 1'b1 && k < 40) begin
        step();
        k++;
      end
      chk("wd_conf_seen", bp_conf, 1);
      bp_idle = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 80) begin
        step();
        k++;
      end
      chk("wd_done_seen", done, 1);
      chk("wd_err", err, 1);
      chk("wd_valid", bank_valid, 2'b00);
      bp_idle = 1'b1;
      step();
      step();
      chk("wd_err_sticky", err, 1);
      job(32'h0000_6000, 32'h0000_0100, 16'd0);
      chk("wd_err_clear", err, 0);
      step();
      step();
    end
`endif

    // Reset mid-job
    job(32'h0000_3000, 32'h0000_0100, 16'd2);
    serve("mid_t0", 32'h0000_3000, 2'd0);
    step();
    chk("mid_valid", bank_valid, 2'b01);
    step();
    chk("mid_conf", bp_conf, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_conf", bp_conf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
